// File: rtl/sync_fifo.sv
// ============================================================================
//  Module   : sync_fifo
//  Purpose  : Single-clock show-ahead FIFO with occupancy-decoded status flags.
//  Revision : 1.0  - initial release
// ============================================================================
`default_nettype none

module sync_fifo #(
  parameter int NUM_SLOTS     = 4,
  parameter int LOG_NUM_SLOTS = 2,
  parameter int DATA_WIDTH    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_write,
  input  logic                  write,
  output logic                  full,
  output logic                  almost_full,
  output logic [DATA_WIDTH-1:0] data_read,
  input  logic                  next_read,
  output logic                  empty
);

  localparam logic [LOG_NUM_SLOTS:0]   C_FULL_CNT  = (LOG_NUM_SLOTS+1)'(NUM_SLOTS);
  localparam logic [LOG_NUM_SLOTS:0]   C_AFULL_CNT = (LOG_NUM_SLOTS+1)'(NUM_SLOTS - 1);
  localparam logic [LOG_NUM_SLOTS-1:0] C_PTR_ONE   = LOG_NUM_SLOTS'(1);

  logic [DATA_WIDTH-1:0]    mem_q [NUM_SLOTS];
  logic [LOG_NUM_SLOTS-1:0] wr_ptr_q, wr_ptr_d;
  logic [LOG_NUM_SLOTS-1:0] rd_ptr_q, rd_ptr_d;
  logic [LOG_NUM_SLOTS:0]   count_q,  count_d;

  logic w_push;
  logic w_pop;

  // Flags come only from the registered count, so they never combinationally
  // follow write/next_read.
  assign full        = (count_q == C_FULL_CNT);
  assign almost_full = (count_q >= C_AFULL_CNT);
  assign empty       = (count_q == '0);

  assign w_push = write     & ~full;
  assign w_pop  = next_read & ~empty;

  assign data_read = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (w_push) wr_ptr_d = wr_ptr_q + C_PTR_ONE;
    if (w_pop)  rd_ptr_d = rd_ptr_q + C_PTR_ONE;
    case ({w_push, w_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage entries are cleared on reset so data_read reads back zero.
  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_mem
    always_ff @(posedge clk) begin
      if (!rst) begin
        mem_q[g] <= '0;
      end else if (w_push && (wr_ptr_q == LOG_NUM_SLOTS'(g))) begin
        mem_q[g] <= data_write;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sync_fifo.sv
// ============================================================================
//  Module   : tb_sync_fifo
//  Purpose  : Directed self-checking bench for sync_fifo (4 x 8 configuration).
//  Revision : 1.0  - initial release
// ============================================================================
`default_nettype none

module tb_sync_fifo;

  logic       clk;
  logic       rst;
  logic [7:0] data_write;
  logic       write;
  logic       full;
  logic       almost_full;
  logic [7:0] data_read;
  logic       next_read;
  logic       empty;

  int n_run;
  int n_fail;

  sync_fifo #(
    .NUM_SLOTS    (4),
    .LOG_NUM_SLOTS(2),
    .DATA_WIDTH   (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .data_write (data_write),
    .write      (write),
    .full       (full),
    .almost_full(almost_full),
    .data_read  (data_read),
    .next_read  (next_read),
    .empty      (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_flags(input string tag, input logic e, input logic af, input logic f);
    check({tag, ".empty"},       32'(empty),       32'(e));
    check({tag, ".almost_full"}, 32'(almost_full), 32'(af));
    check({tag, ".full"},        32'(full),        32'(f));
  endtask

  initial begin
    n_run      = 0;
    n_fail     = 0;
    rst        = 1'b0;
    write      = 1'b0;
    next_read  = 1'b0;
    data_write = 8'h00;

    // Reset, then idle
    step();
    rst = 1'b1;
    step();
    check_flags("reset", 1'b1, 1'b0, 1'b0);
    check("reset.data_read", 32'(data_read), 32'h00);

    // Fill with 11,22,33
    write = 1'b1; data_write = 8'h11; step();
    check("push11.empty", 32'(empty), 32'd0);
    check("push11.data_read", 32'(data_read), 32'h11);
    data_write = 8'h22; step();
    data_write = 8'h33; step();
    check_flags("occ3", 1'b0, 1'b1, 1'b0);
    check("occ3.data_read", 32'(data_read), 32'h11);

    // 4th word -> full, 5th dropped
    data_write = 8'h44; step();
    check_flags("occ4", 1'b0, 1'b1, 1'b1);
    data_write = 8'h55; step();
    check_flags("drop55", 1'b0, 1'b1, 1'b1);
    check("drop55.data_read", 32'(data_read), 32'h11);

    // Drain: 11 (already shown), 22, 33, 44, then empty
    write = 1'b0; next_read = 1'b1;
    step(); check("pop1.data_read", 32'(data_read), 32'h22);
    step(); check("pop2.data_read", 32'(data_read), 32'h33);
    step(); check("pop3.data_read", 32'(data_read), 32'h44);
    step(); check_flags("drained", 1'b1, 1'b0, 1'b0);

    // Pop while empty combined with push of A5: push wins, pop ignored
    write = 1'b1; data_write = 8'hA5; next_read = 1'b1; step();
    check_flags("popempty", 1'b0, 1'b0, 1'b0);
    check("popempty.data_read", 32'(data_read), 32'hA5);

    // Occupancy 2
    next_read = 1'b0; data_write = 8'hB6; step();
    check("occ2.data_read", 32'(data_read), 32'hA5);

    // 8 cycles of push+pop, pattern 0x60.. ; queue A5,B6 -> B6,60 -> 60,61 ...
    next_read = 1'b1;
    for (int k = 0; k < 8; k++) begin
      data_write = 8'h60 + 8'(k);
      step();
      check($sformatf("pp%0d.data_read", k), 32'(data_read),
            (k == 0) ? 32'hB6 : 32'(8'h60 + 8'(k - 1)));
      check_flags($sformatf("pp%0d", k), 1'b0, 1'b0, 1'b0);
    end

    // Queue now 66,67; fill to full with 70,71
    next_read = 1'b0;
    data_write = 8'h70; step();
    data_write = 8'h71; step();
    check_flags("refull", 1'b0, 1'b1, 1'b1);
    check("refull.data_read", 32'(data_read), 32'h66);

    // Push+pop while full: only the pop takes effect
    data_write = 8'h99; next_read = 1'b1; step();
    check_flags("fullpp", 1'b0, 1'b1, 1'b0);
    check("fullpp.data_read", 32'(data_read), 32'h67);

    // Drain and verify 99 was never stored
    write = 1'b0;
    step(); check("drain2a.data_read", 32'(data_read), 32'h70);
    step(); check("drain2b.data_read", 32'(data_read), 32'h71);
    step(); check_flags("drain2", 1'b1, 1'b0, 1'b0);

    // Refill to full, then reset mid-operation with write asserted
    next_read = 1'b0; write = 1'b1;
    for (int k = 0; k < 4; k++) begin
      data_write = 8'hC0 + 8'(k);
      step();
    end
    check_flags("prerst", 1'b0, 1'b1, 1'b1);
    rst = 1'b0; data_write = 8'hEE; step();
    check_flags("midrst", 1'b1, 1'b0, 1'b0);
    check("midrst.data_read", 32'(data_read), 32'h00);
    rst = 1'b1; write = 1'b0; step();
    check_flags("postrst", 1'b1, 1'b0, 1'b0);
    check("postrst.data_read", 32'(data_read), 32'h00);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
